// File: rtl/sd_sector_assembler.sv
// Packs the SD write FIFO byte stream into ping-pong sector buffers A/B and
// streams each full sector to the SD controller on a request/ack/pull/done handshake.
module sd_sector_assembler #(
    parameter int unsigned       SECTOR_BYTES = 512,
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] START_BLOCK  = 'd2048,
    parameter logic [7:0]        PAD_BYTE     = 8'h00
) (
    input  logic              clk210_p,
    input  logic              reset_p,
    input  logic [7:0]        sd_write_fifo_dout_p,
    input  logic              sd_write_fifo_empty_p,
    output logic              sd_write_fifo_rd_en_p,
    input  logic              flush_p,
    output logic              sd_block_req_p,
    output logic [ADDR_W-1:0] sd_block_addr_p,
    input  logic              sd_block_ack_p,
    input  logic              sd_byte_rd_p,
    output logic [7:0]        sd_byte_p,
    input  logic              sd_block_done_p,
    output logic [ADDR_W-1:0] blocks_written_p,
    output logic              busy_p
);

    localparam int unsigned      IDX_W    = $clog2(SECTOR_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = '1;
    localparam logic [IDX_W:0]   SEC_CNT  = (IDX_W+1)'(SECTOR_BYTES);

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_FILLING,
        BUF_FULL,
        BUF_DRAINING
    } buf_state_t;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_REQ,
        DR_XFER,
        DR_WAIT_DONE
    } drain_state_t;

    logic [7:0]        r_ram_a [SECTOR_BYTES];
    logic [7:0]        r_ram_b [SECTOR_BYTES];
    buf_state_t        r_buf_st [2];
    logic              r_fill_sel;
    logic              r_drain_sel;
    logic [IDX_W-1:0]  r_fill_idx;
    logic [IDX_W-1:0]  r_drain_idx;
    logic              r_in_flight;
    logic              r_flush_pend;
    logic              r_padding;
    drain_state_t      r_state;
    drain_state_t      w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_blocks;
    logic [7:0]        r_byte;

    buf_state_t        w_fill_st;
    buf_state_t        w_drain_st;
    logic              w_fill_open;
    logic              w_room;
    logic              w_rd_en;
    logic              w_wr;
    logic              w_wr_last;
    logic [7:0]        w_wr_data;
    logic              w_pad_start;
    logic              w_flush_drop;
    logic [7:0]        w_ram_q;
    logic              w_req;
    logic              w_ack_take;
    logic              w_rd_take;
    logic              w_done_take;

    // Fill side: a read is only issued if its byte is guaranteed a slot in the
    // current buffer, so nothing is ever dropped when the other buffer is busy.
    always_comb begin
        w_fill_st    = r_buf_st[r_fill_sel];
        w_fill_open  = (w_fill_st == BUF_EMPTY) || (w_fill_st == BUF_FILLING);
        w_room       = ({1'b0, r_fill_idx} + {{IDX_W{1'b0}}, r_in_flight}) < SEC_CNT;
        w_rd_en      = !sd_write_fifo_empty_p && w_fill_open && !r_padding &&
                       !r_flush_pend && w_room;
        w_wr         = r_in_flight || r_padding;
        w_wr_data    = r_padding ? PAD_BYTE : sd_write_fifo_dout_p;
        w_wr_last    = w_wr && (r_fill_idx == LAST_IDX);
        w_pad_start  = r_flush_pend && !r_padding && !r_in_flight && w_fill_open &&
                       (r_fill_idx != '0);
        w_flush_drop = r_flush_pend && !r_padding && !r_in_flight && w_fill_open &&
                       (r_fill_idx == '0);
        w_drain_st   = r_buf_st[r_drain_sel];
        w_ram_q      = r_drain_sel ? r_ram_b[r_drain_idx] : r_ram_a[r_drain_idx];
    end

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_ack_take   = 1'b0;
        w_rd_take    = 1'b0;
        w_done_take  = 1'b0;
        case (r_state)
            DR_IDLE: begin
                if (w_drain_st == BUF_FULL) begin
                    w_next_state = DR_REQ;
                end
            end
            DR_REQ: begin
                w_req = 1'b1;
                if (sd_block_ack_p) begin
                    w_ack_take   = 1'b1;
                    w_next_state = DR_XFER;
                end
            end
            DR_XFER: begin
                if (sd_byte_rd_p) begin
                    w_rd_take = 1'b1;
                    if (r_drain_idx == LAST_IDX) begin
                        w_next_state = DR_WAIT_DONE;
                    end
                end
            end
            DR_WAIT_DONE: begin
                if (sd_block_done_p) begin
                    w_done_take  = 1'b1;
                    w_next_state = DR_IDLE;
                end
            end
            default: w_next_state = DR_IDLE;
        endcase
    end

    always_ff @(posedge clk210_p) begin
        if (!reset_p) begin
            r_state <= DR_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Fill and drain never touch the same buffer status in one cycle: fill only
    // moves EMPTY/FILLING buffers, drain only FULL/DRAINING ones.
    always_ff @(posedge clk210_p) begin
        if (!reset_p) begin
            r_buf_st[0]  <= BUF_EMPTY;
            r_buf_st[1]  <= BUF_EMPTY;
            r_fill_sel   <= 1'b0;
            r_drain_sel  <= 1'b0;
            r_fill_idx   <= '0;
            r_drain_idx  <= '0;
            r_in_flight  <= 1'b0;
            r_flush_pend <= 1'b0;
            r_padding    <= 1'b0;
            r_addr       <= START_BLOCK;
            r_blocks     <= '0;
            r_byte       <= '0;
        end else begin
            r_in_flight <= w_rd_en;
            if (flush_p) begin
                r_flush_pend <= 1'b1;
            end
            if (w_flush_drop) begin
                r_flush_pend <= 1'b0;
            end
            if (w_pad_start) begin
                r_padding <= 1'b1;
            end
            if (w_wr) begin
                r_fill_idx <= r_fill_idx + IDX_W'(1);
                if (w_wr_last) begin
                    r_buf_st[r_fill_sel] <= BUF_FULL;
                    r_fill_sel           <= ~r_fill_sel;
                    if (r_padding) begin
                        r_padding    <= 1'b0;
                        r_flush_pend <= 1'b0;
                    end
                end else begin
                    r_buf_st[r_fill_sel] <= BUF_FILLING;
                end
            end
            if (w_ack_take) begin
                r_buf_st[r_drain_sel] <= BUF_DRAINING;
                r_drain_idx           <= '0;
            end
            if (w_rd_take) begin
                r_byte      <= w_ram_q;
                r_drain_idx <= r_drain_idx + IDX_W'(1);
            end
            if (w_done_take) begin
                r_buf_st[r_drain_sel] <= BUF_EMPTY;
                r_drain_sel           <= ~r_drain_sel;
                r_addr                <= r_addr + ADDR_W'(1);
                r_blocks              <= r_blocks + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk210_p) begin
        if (w_wr) begin
            if (r_fill_sel) begin
                r_ram_b[r_fill_idx] <= w_wr_data;
            end else begin
                r_ram_a[r_fill_idx] <= w_wr_data;
            end
        end
    end

    assign sd_write_fifo_rd_en_p = w_rd_en;
    assign sd_block_req_p        = w_req;
    assign sd_block_addr_p       = r_addr;
    assign sd_byte_p             = r_byte;
    assign blocks_written_p      = r_blocks;
    assign busy_p                = (r_buf_st[0] != BUF_EMPTY) || (r_buf_st[1] != BUF_EMPTY) ||
                                   r_flush_pend;

endmodule

// File: tb/tb_sd_sector_assembler.sv
// Scoreboard bench for sd_sector_assembler: driver pushes expected bytes/addresses,
// a monitor pops and compares on every accepted byte pull and every new request.
module tb_sd_sector_assembler;

    localparam int SB = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_empty = 1'b1;
    logic        rd_en;
    logic        flush = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0;
    logic        byte_rd = 1'b0;
    logic [7:0]  sbyte;
    logic        done = 1'b0;
    logic [31:0] blocks;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int fifo_pops = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  q_byte[$];
    logic [31:0] q_addr[$];

    logic s_rst, s_req, s_ack, s_rd, prev_req;
    bit   pulled;
    bit   mon_in_xfer = 1'b0;
    int   mon_pulls = 0;

    sd_sector_assembler #(
        .SECTOR_BYTES(512),
        .ADDR_W      (32),
        .START_BLOCK (32'd2048),
        .PAD_BYTE    (8'h00)
    ) dut (
        .clk210_p              (clk),
        .reset_p               (rst_n),
        .sd_write_fifo_dout_p  (fifo_dout),
        .sd_write_fifo_empty_p (fifo_empty),
        .sd_write_fifo_rd_en_p (rd_en),
        .flush_p               (flush),
        .sd_block_req_p        (req),
        .sd_block_addr_p       (addr),
        .sd_block_ack_p        (ack),
        .sd_byte_rd_p          (byte_rd),
        .sd_byte_p             (sbyte),
        .sd_block_done_p       (done),
        .blocks_written_p      (blocks),
        .busy_p                (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Standard-mode FIFO model: data appears one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            if (fifo_q.size() > 0) begin
                fifo_dout <= fifo_q.pop_front();
                fifo_pops++;
            end else begin
                tests++;
                fails++;
                $display("FAIL fifo_underflow: got rd_en=1 while empty, expected rd_en=0");
            end
        end
    end

    always @(negedge clk) fifo_empty <= (fifo_q.size() == 0);

    initial begin
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            s_rst  = rst_n;
            s_req  = req;
            s_ack  = ack;
            s_rd   = byte_rd;
            pulled = 1'b0;
            if (!s_rst) begin
                mon_in_xfer = 1'b0;
                mon_pulls   = 0;
            end else if (mon_in_xfer && s_rd) begin
                pulled = 1'b1;
                mon_pulls++;
                if (mon_pulls == SB) mon_in_xfer = 1'b0;
            end else if (s_req && s_ack) begin
                mon_in_xfer = 1'b1;
                mon_pulls   = 0;
            end
            #2;
            if (pulled) begin
                if (q_byte.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sector_byte: got 0x%0h with no byte expected", sbyte);
                end else begin
                    check("sector_byte", sbyte, q_byte.pop_front());
                end
            end
            if (req && !prev_req) begin
                if (q_addr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL req_addr: got request at 0x%0h with none expected", addr);
                end else begin
                    check("req_addr", addr, q_addr.pop_front());
                end
            end
            prev_req = req;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        q_byte.push_back(b);
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int n = 0;
        while (fifo_pops < target && n < budget) begin
            tick();
            n++;
        end
        check(name, (fifo_pops >= target), 1);
    endtask

    task automatic wait_req(input int budget, input string name);
        int n = 0;
        while (!req && n < budget) begin
            tick();
            n++;
        end
        check(name, req, 1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic pull(input int n);
        byte_rd = 1'b1;
        tick_n(n);
        byte_rd = 1'b0;
    endtask

    task automatic do_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic run_block(input string name);
        wait_req(3000, name);
        do_ack();
        pull(SB);
        do_done();
    endtask

    task automatic apply_reset();
        fifo_q.delete();
        byte_rd = 1'b0;
        ack     = 1'b0;
        done    = 1'b0;
        flush   = 1'b0;
        rst_n   = 1'b0;
        tick_n(3);
        q_byte.delete();
        q_addr.delete();
        fifo_pops = 0;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;

        apply_reset();
        check("rst_req", req, 0);
        check("rst_addr", addr, 2048);
        check("rst_blocks", blocks, 0);
        check("rst_busy", busy, 0);
        check("rst_byte", sbyte, 0);
        check("rst_rd_en", rd_en, 0);

        // One full sector from a never-empty FIFO.
        q_addr.push_back(32'd2048);
        for (int i = 0; i < SB; i++) push_byte(8'(i));
        wait_pops(SB, 2000, "t1_fill");
        n = 0;
        while (!req && n < 10) begin
            tick();
            n++;
        end
        check("t1_req_latency", n, 2);
        do_ack();
        pull(SB);
        do_done();
        tick();
        check("t1_blocks", blocks, 1);
        check("t1_addr", addr, 2049);
        check("t1_busy", busy, 0);
        check("t1_q_empty", q_byte.size(), 0);

        // Backpressure: both buffers full while the request is held off.
        apply_reset();
        q_addr.push_back(32'd2048);
        q_addr.push_back(32'd2049);
        q_addr.push_back(32'd2050);
        for (int i = 0; i < 3 * SB; i++) push_byte(8'(i ^ (i >> 8)));
        wait_pops(2 * SB, 3000, "t2_fill_two");
        tick_n(30);
        check("t2_pops_stall", fifo_pops, 2 * SB);
        check("t2_rd_en_low", rd_en, 0);
        check("t2_busy", busy, 1);
        check("t2_req", req, 1);
        do_ack();
        pull(SB);
        tick_n(5);
        check("t2_pops_before_done", fifo_pops, 2 * SB);
        do_done();
        wait_pops(3 * SB, 2000, "t2_fill_third");
        run_block("t2_req_b");
        run_block("t2_req_a2");
        tick();
        check("t2_blocks", blocks, 3);
        check("t2_addr", addr, 2051);
        check("t2_busy", busy, 0);
        check("t2_q_empty", q_byte.size(), 0);

        // Flush of a partial sector, then a flush with nothing buffered.
        apply_reset();
        q_addr.push_back(32'd2048);
        push_byte(8'hAA);
        push_byte(8'hBB);
        push_byte(8'hCC);
        wait_pops(3, 50, "t3_fill");
        tick_n(3);
        check("t3_no_req_before_flush", req, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < SB - 3; i++) q_byte.push_back(8'h00);
        run_block("t3_req");
        tick();
        check("t3_blocks", blocks, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick_n(10);
        check("t3_empty_flush_req", req, 0);
        check("t3_empty_flush_busy", busy, 0);
        check("t3_empty_flush_blocks", blocks, 1);

        // Stray done during REQ, then byte pulls held high past the sector end.
        q_addr.push_back(32'd2049);
        for (int i = 0; i < SB; i++) push_byte(8'(i * 3 + 1));
        wait_req(2000, "t4_req");
        do_done();
        tick();
        check("t4_stray_done_addr", addr, 2049);
        check("t4_stray_done_blocks", blocks, 1);
        check("t4_stray_done_req", req, 1);
        do_ack();
        pull(600);
        tick();
        check("t4_byte_hold", sbyte, 8'hFE);
        check("t4_q_empty", q_byte.size(), 0);
        check("t4_req_after_xfer", req, 0);
        do_done();
        tick();
        check("t4_blocks", blocks, 2);
        check("t4_addr", addr, 2050);

        // Reset in the middle of a transfer abandons the sector.
        q_addr.push_back(32'd2050);
        for (int i = 0; i < SB; i++) push_byte(8'(i));
        wait_req(2000, "t5_req");
        do_ack();
        pull(100);
        tick();
        apply_reset();
        check("t5_rst_req", req, 0);
        check("t5_rst_addr", addr, 2048);
        check("t5_rst_blocks", blocks, 0);
        check("t5_rst_busy", busy, 0);
        q_addr.push_back(32'd2048);
        for (int i = 0; i < SB; i++) push_byte(8'(i) ^ 8'hA5);
        run_block("t5_req_after_rst");
        tick();
        check("t5_blocks", blocks, 1);
        check("t5_addr", addr, 2049);
        check("t5_q_empty", q_byte.size(), 0);

        // Done for A lands on the same edge as B's last byte write.
        apply_reset();
        q_addr.push_back(32'd2048);
        q_addr.push_back(32'd2049);
        q_addr.push_back(32'd2050);
        for (int i = 0; i < 2 * SB - 1; i++) push_byte(8'(i * 5 + 7));
        wait_req(2000, "t6_req_a");
        do_ack();
        pull(SB);
        wait_pops(2 * SB - 1, 2000, "t6_fill_b_partial");
        tick_n(3);
        check("t6_req_wait_done", req, 0);
        for (int i = 2 * SB - 1; i < 3 * SB; i++) push_byte(8'(i * 5 + 7));
        wait_pops(2 * SB, 20, "t6_last_b_read");
        do_done();
        n = 1;
        while (!req && n < 10) begin
            tick();
            n++;
        end
        check("t6_req_within_2", (n <= 2), 1);
        do_ack();
        pull(SB);
        do_done();
        run_block("t6_req_a2");
        tick();
        check("t6_pops", fifo_pops, 3 * SB);
        check("t6_blocks", blocks, 3);
        check("t6_addr", addr, 2051);
        check("t6_busy", busy, 0);
        check("t6_q_empty", q_byte.size(), 0);
        check("t6_addr_q_empty", q_addr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
